// File: rtl/updown_cnt_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter family.
// Optional feature macro used by the counter: GRAY_OUT_EN.
package updown_cnt_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Out-of-range load values land on the top state, never outside 0..modulus-1.
    function automatic int unsigned clamp_load(input int unsigned val,
                                               input int unsigned modulus);
        return (val > modulus - 1) ? modulus - 1 : val;
    endfunction

endpackage

// File: rtl/cnt_onehot_dec.sv
// One-hot decode of the counter state: bit i is set while count == i.
module cnt_onehot_dec #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic [WIDTH-1:0]   count,
    output logic [MODULUS-1:0] dec
);

    for (genvar i = 0; i < MODULUS; i++) begin : g_dec
        assign dec[i] = (count == WIDTH'(i));
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Parametrised modulo-N up/down step counter with load, terminal count, wrap pulse
// and saturate mode. Define GRAY_OUT_EN to add the Gray-coded count output.
module updown_mod_counter
    import updown_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int SAT     = 0
) (
    input  logic               clk,
    input  logic               res,
    input  logic               en,
    input  logic               dir,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    output logic [WIDTH-1:0]   count,
    output logic [MODULUS-1:0] dec,
    output logic               tc,
    output logic               wrap
`ifdef GRAY_OUT_EN
    ,
    output logic [WIDTH-1:0]   gray
`endif
);

    if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
        $error("updown_mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_load_clamped;

    assign w_load_clamped = WIDTH'(clamp_load(32'(load_val), 32'(MODULUS)));

    // Next state: load beats step; wrap only flags an actual limit crossing.
    always_comb begin
        w_cnt_nxt  = r_count;
        w_wrap_nxt = 1'b0;
        if (load) begin
            w_cnt_nxt = w_load_clamped;
        end else if (en) begin
            if (dir == DIR_UP) begin
                if (r_count < MAX) begin
                    w_cnt_nxt = r_count + 1'b1;
                end else if (SAT != MODE_SAT) begin
                    w_cnt_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end
            end else begin
                if (r_count != '0) begin
                    w_cnt_nxt = r_count - 1'b1;
                end else if (SAT != MODE_SAT) begin
                    w_cnt_nxt  = MAX;
                    w_wrap_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign tc    = en & ((dir & (r_count == MAX)) | (~dir & (r_count == '0)));

    cnt_onehot_dec #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_dec (
        .count (r_count),
        .dec   (dec)
    );

`ifdef GRAY_OUT_EN
    assign gray = r_count ^ (r_count >> 1);
`endif

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: a wrapping and a saturating instance
// (WIDTH=4, MODULUS=10) share one stimulus stream; GRAY_OUT_EN adds a MODULUS=16 instance.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] a_count, s_count;
    logic [9:0] a_dec, s_dec;
    logic       a_tc, s_tc, a_wrap, s_wrap;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SAT(0)) dut (
        .clk(clk), .res(res), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .count(a_count), .dec(a_dec), .tc(a_tc), .wrap(a_wrap)
`ifdef GRAY_OUT_EN
        , .gray()
`endif
    );

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SAT(1)) dut_sat (
        .clk(clk), .res(res), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .count(s_count), .dec(s_dec), .tc(s_tc), .wrap(s_wrap)
`ifdef GRAY_OUT_EN
        , .gray()
`endif
    );

`ifdef GRAY_OUT_EN
    logic [3:0]  g_count, g_gray;
    logic [15:0] g_dec;
    logic        g_tc, g_wrap;
    updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SAT(0)) dut_gray (
        .clk(clk), .res(res), .en(en), .dir(dir), .load(load), .load_val(load_val),
        .count(g_count), .dec(g_dec), .tc(g_tc), .wrap(g_wrap), .gray(g_gray)
    );
`endif

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int up_a[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    int dn_a[3]  = '{9, 8, 7};

    initial begin
        // Reset dominates load and enable
        res = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd7; dir = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("rst_cnt", 32'(a_count), 0);
            chk("rst_dec", 32'(a_dec), 32'h001);
            chk("rst_wrap", 32'(a_wrap), 0);
            chk("rst_tc", 32'(a_tc), 0);
            chk("rst_sat_cnt", 32'(s_count), 0);
        end

        // Count up through the wrap point
        res = 1'b0; load = 1'b0; en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("up_cnt", 32'(a_count), 32'(up_a[i]));
            chk("up_wrap", 32'(a_wrap), 32'(up_a[i] == 0 && i == 9));
            chk("up_tc", 32'(a_tc), 32'(up_a[i] == 9));
            chk("up_sat_cnt", 32'(s_count), (i < 8) ? 32'(i + 1) : 32'd9);
            chk("up_sat_wrap", 32'(s_wrap), 0);
        end

        // Return to 0, then count down across the lower limit
        en = 1'b0; load = 1'b1; load_val = 4'd0;
        step();
        chk("ld0_cnt", 32'(a_count), 0);
        chk("ld0_sat_cnt", 32'(s_count), 0);
        load = 1'b0; en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dn_cnt", 32'(a_count), 32'(dn_a[i]));
            chk("dn_wrap", 32'(a_wrap), 32'(i == 0));
            chk("dn_sat_cnt", 32'(s_count), 0);
            chk("dn_sat_wrap", 32'(s_wrap), 0);
            chk("dn_sat_tc", 32'(s_tc), 1);
            if (i == 0) chk("dn_dec9", 32'(a_dec), 32'h200);
        end

        // Load clamps, and load wins over a simultaneous step
        en = 1'b0; load = 1'b1; load_val = 4'd13;
        step();
        chk("ld13_cnt", 32'(a_count), 9);
        chk("ld13_wrap", 32'(a_wrap), 0);
        en = 1'b1; dir = 1'b1; load_val = 4'd5;
        step();
        chk("ldpri_cnt", 32'(a_count), 5);
        chk("ldpri_wrap", 32'(a_wrap), 0);
        chk("ldpri_sat_cnt", 32'(s_count), 5);

        // Saturate at the top versus wrap
        en = 1'b0; load_val = 4'd9;
        step();
        load = 1'b0; en = 1'b1; dir = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sat_top_cnt", 32'(s_count), 9);
            chk("sat_top_wrap", 32'(s_wrap), 0);
            chk("wrap_top_cnt", 32'(a_count), 32'(i));
            chk("wrap_top_wrap", 32'(a_wrap), 32'(i == 0));
        end

        // Saturate at the bottom
        en = 1'b0; load = 1'b1; load_val = 4'd0;
        step();
        load = 1'b0; en = 1'b1; dir = 1'b0;
        step();
        chk("sat_bot_cnt", 32'(s_count), 0);
        chk("wrap_bot_cnt", 32'(a_count), 9);
        chk("wrap_bot_wrap", 32'(a_wrap), 1);

        // Reset mid-operation, then counting resumes
        en = 1'b0; load = 1'b1; load_val = 4'd6;
        step();
        chk("ld6_cnt", 32'(a_count), 6);
        load = 1'b0; en = 1'b1; dir = 1'b1; res = 1'b1;
        step();
        chk("midrst_cnt", 32'(a_count), 0);
        chk("midrst_dec", 32'(a_dec), 32'h001);
        res = 1'b0;
        step();
        chk("resume1_cnt", 32'(a_count), 1);
        step();
        chk("resume2_cnt", 32'(a_count), 2);

        // Idle hold, then an immediate direction change
        en = 1'b0;
        step();
        chk("idle_cnt", 32'(a_count), 2);
        chk("idle_wrap", 32'(a_wrap), 0);
        chk("idle_tc", 32'(a_tc), 0);
        en = 1'b1; dir = 1'b0;
        step();
        chk("dirchg_cnt", 32'(a_count), 1);

`ifdef GRAY_OUT_EN
        en = 1'b0; load = 1'b1; load_val = 4'd7;
        step();
        chk("gray7", 32'(g_gray), 32'h4);
        load = 1'b0; en = 1'b1; dir = 1'b1;
        step();
        chk("gray8_cnt", 32'(g_count), 8);
        chk("gray8", 32'(g_gray), 32'hC);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
